alu_mcycle_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer that borrows the processor's 32-bit combinational ALU, one add or subtract per cycle, instead of instantiating its own wide arithmetic.
- Sits beside the execute stage: the decoder issues Start with operands, the pipeline stalls on Busy, and Result1/Result2 are written back after Done.
- ALU access is gated by a grant from the execute-stage ALU mux, so normal instructions keep priority.

---
 rtl/alu_mcycle_seq_pkg.sv | 9 +
 rtl/alu_mcycle_seq.sv | 82 ++++++++
 tb/tb_alu_mcycle_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_mcycle_seq_pkg.sv
// alu_mcycle_seq_pkg: ALU opcodes, MCycle op codes and sequencer state encoding
package alu_mcycle_seq_pkg;
  localparam int WIDTH = 32;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/alu_mcycle_seq.sv
// alu_mcycle_seq: unsigned multiply/divide sequencer stepping one add/sub per cycle on the shared ALU
module alu_mcycle_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             ALU_Req,
  input  logic             ALU_Gnt,
  output logic [WIDTH-1:0] Src_A,
  output logic [WIDTH-1:0] Src_B,
  output logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult
);
  import alu_mcycle_seq_pkg::*;
  state_t state, state_n;
  logic op, it, mul, step, last, c, ge;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, sh, m, acc_n, sh_n;
  logic [WIDTH:0] t;
  // acc/sh/m hold hi/lo/mcand for multiply and rem/quo/dvs for divide
  always_comb begin
    it = state == ITER;
    mul = op == OP_MUL;
    t = {acc, sh[WIDTH-1]};
    c = ALUResult < acc;
    ge = t[WIDTH] | (t[WIDTH-1:0] >= m);
    acc_n = mul ? {c, ALUResult[WIDTH-1:1]} : (ge ? ALUResult : t[WIDTH-1:0]);
    sh_n = mul ? {ALUResult[0], sh[WIDTH-1:1]} : {sh[WIDTH-2:0], ge};
    step = it & ALU_Gnt;
    last = step & (cnt == CNT_W'(WIDTH - 1));
  end
  always_ff @(posedge CLK)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (Start ? ITER : IDLE) :
              state == ITER ? (last ? DONE : ITER) : IDLE;
  always_comb begin
    Busy = it;
    Done = state == DONE;
    ALU_Req = it;
    Src_A = it ? (mul ? acc : t[WIDTH-1:0]) : '0;
    Src_B = it ? ((mul & ~sh[0]) ? '0 : m) : '0;
    ALUControl = it ? (mul ? ALU_ADD : ALU_SUB) : 4'b0000;
  end
  always_ff @(posedge CLK)
    if (Reset) begin
      op <= 1'b0;
      cnt <= '0;
      acc <= '0;
      sh <= '0;
      m <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      if (state == IDLE && Start) begin
        op <= MCycleOp;
        cnt <= '0;
        acc <= '0;
        sh <= MCycleOp ? Operand1 : Operand2;
        m <= MCycleOp ? Operand2 : Operand1;
      end
      if (step) begin
        acc <= acc_n;
        sh <= sh_n;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        Result1 <= sh_n;
        Result2 <= acc_n;
      end
    end
endmodule

// File: tb/tb_alu_mcycle_seq.sv
// tb_alu_mcycle_seq: scoreboard bench with a phase-level sequencer model and a behavioural ALU
module tb_alu_mcycle_seq;
  logic CLK = 0, Reset = 1, Start = 0, MCycleOp = 0, ALU_Gnt = 1;
  logic Busy, Done, ALU_Req;
  logic [31:0] Operand1 = 0, Operand2 = 0, Result1, Result2, Src_A, Src_B, ALUResult;
  logic [3:0] ALUControl;
  typedef struct {logic [31:0] r1; logic [31:0] r2;} exp_t;
  exp_t q[$];
  int passed = 0, total = 0, phase = 0, grants = 0, lows = 0, cyc = 0, acc_cyc = 0;
  logic m_op = 0;
  logic [31:0] held1 = 0, held2 = 0;

  always #5 CLK = ~CLK;

  alu_mcycle_seq dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .Busy(Busy), .Done(Done), .ALU_Req(ALU_Req), .ALU_Gnt(ALU_Gnt),
    .Src_A(Src_A), .Src_B(Src_B), .ALUControl(ALUControl), .ALUResult(ALUResult)
  );

  assign ALUResult = ALUControl == 4'b0100 ? Src_A + Src_B :
                     ALUControl == 4'b0010 ? Src_A - Src_B : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  // monitor: phase model (0 idle, 1 iter, 2 done) advanced from the inputs the bench drives
  initial begin
    exp_t e;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      cyc++;
      chk("busy", 64'(Busy), 64'(phase == 1));
      chk("done", 64'(Done), 64'(phase == 2));
      chk("alu_req", 64'(ALU_Req), 64'(phase == 1));
      if (phase == 1) chk("alu_ctl", 64'(ALUControl), m_op ? 64'h2 : 64'h4);
      else begin
        chk("src_idle", {Src_A, Src_B}, 64'h0);
        chk("ctl_idle", 64'(ALUControl), 64'h0);
      end
      if (phase == 2) begin
        if (q.size() == 0) chk("queue_empty", 64'h1, 64'h0);
        else begin
          e = q.pop_front();
          held1 = e.r1;
          held2 = e.r2;
          chk("latency", 64'(cyc - acc_cyc), 64'(33 + lows));
        end
      end
      chk("result1", 64'(Result1), 64'(held1));
      chk("result2", 64'(Result2), 64'(held2));
      if (Reset) begin
        phase = 0;
        q.delete();
        held1 = 0;
        held2 = 0;
      end else if (phase == 0) begin
        if (Start) begin
          phase = 1;
          grants = 0;
          lows = 0;
          acc_cyc = cyc;
          m_op = MCycleOp;
        end
      end else if (phase == 1) begin
        if (ALU_Gnt) begin
          grants++;
          if (grants == 32) phase = 2;
        end else lows++;
      end else phase = 0;
    end
  end

  // mode: 0 grant high, 1 five scattered grant-low cycles, 2 random grant,
  // 3 random grant plus Start toggling while busy, 5 reset after ten steps
  task automatic run(input logic op, input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t e;
    logic [63:0] p;
    int n = 0, guard = 0;
    bit rst_done = 0;
    while (phase != 0 && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    p = 64'(a) * 64'(b);
    if (op) begin
      e.r1 = b == 0 ? 32'hFFFF_FFFF : a / b;
      e.r2 = b == 0 ? a : a % b;
    end else begin
      e.r1 = p[31:0];
      e.r2 = p[63:32];
    end
    q.push_back(e);
    Start = 1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    @(posedge CLK); #1;
    Start = 0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    MCycleOp = $urandom_range(0, 1);
    guard = 0;
    while (phase != 0 && guard < 200) begin
      ALU_Gnt = mode == 0 || mode == 5 ? 1'b1 :
                mode == 1 ? !(n inside {2, 7, 13, 20, 29}) : ($urandom_range(0, 3) != 0);
      if (mode == 3) Start = $urandom_range(0, 1);
      if (mode == 5 && !rst_done && phase == 1 && grants == 10) begin
        Reset = 1;
        rst_done = 1;
      end else Reset = 0;
      n++;
      @(posedge CLK); #1;
      guard++;
    end
    chk("timeout", 64'(guard < 200), 64'h1);
    Reset = 0;
    Start = 0;
    ALU_Gnt = 1;
  endtask

  initial begin
    logic [31:0] b;
    repeat (2) @(posedge CLK);
    #1 Reset = 0;
    run(1'b0, 32'h0000_0007, 32'h0000_0006, 0);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(1'b1, 32'd100, 32'd7, 0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run(1'b1, 32'h1234_5678, 32'h0, 0);
    run(1'b0, 32'd3, 32'd5, 1);
    run(1'b1, 32'hDEAD_BEEF, 32'd3, 5);
    run(1'b1, 32'd9, 32'd2, 3);
    for (int i = 0; i < 24; i++) begin
      b = $urandom;
      b = i % 6 == 0 ? 32'h0 : i % 3 == 0 ? b >> $urandom_range(0, 31) : b;
      run(1'($urandom_range(0, 1)), $urandom, b, $urandom_range(2, 3));
    end
    repeat (3) @(posedge CLK);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
